// File: rtl/simon_enc_core.sv
// rtl/simon_enc_core.sv - Iterative Simon32/64 encryption core with on-the-fly key schedule
//
// Purpose : Encrypts one 32-bit block under a 64-bit key, one Feistel round per
//           clock (two per clock when SIMON_UNROLL2_EN is defined). Round keys
//           are generated as the rounds run, so no round-key storage is needed.
// Ports   : i_clk         system clock, rising edge
//           i_rst         asynchronous active-high reset
//           i_en          start pulse; samples i_key and i_plaintext when not busy
//           i_key         {k3,k2,k1,k0}, k0 = i_key[15:0]
//           i_plaintext   {x,y}, x = [31:16], y = [15:0]
//           o_ciphertext  result {x,y}; holds until the next completion
//           o_busy        high while rounds are in progress
//           o_done        one-cycle pulse when o_ciphertext updates
// Config  : SIMON_UNROLL2_EN - two cascaded rounds per clock (16-edge latency)

module simon_enc_core #(
    parameter int n = 16,
    parameter int m = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_en,
    input  logic [63:0] i_key,
    input  logic [31:0] i_plaintext,
    output logic [31:0] o_ciphertext,
    output logic        o_busy,
    output logic        o_done
);

    generate
        if (n != 16 || m != 4) begin : g_bad_param
            $error("simon_enc_core supports only n=16 and m=4");
        end
    endgenerate

    localparam int ROUNDS = 32;
`ifdef SIMON_UNROLL2_EN
    localparam int STEP = 2;
`else
    localparam int STEP = 1;
`endif
    localparam logic [4:0] LAST_ROUND = 5'(ROUNDS - STEP);
    localparam logic [4:0] ROUND_INC  = 5'(STEP);

    // First 32 bits of the Simon z0 sequence; bit i is consumed in round i.
    localparam logic [31:0] Z0 = 32'b10110011100001101010010001011111;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic        w_start;
    logic        w_last;
    logic [15:0] r_x;
    logic [15:0] r_y;
    logic [15:0] r_k0;
    logic [15:0] r_k1;
    logic [15:0] r_k2;
    logic [15:0] r_k3;
    logic [4:0]  r_round;
    logic [31:0] r_ciphertext;
    logic        r_busy;
    logic        r_done;

    function automatic logic [15:0] f_round(input logic [15:0] x);
        return ({x[14:0], x[15]} & {x[7:0], x[15:8]}) ^ {x[13:0], x[15:14]};
    endfunction

    // Next key word from k[i], k[i+1], k[i+3]; ~k and ^3 together form c = 0xFFFC.
    function automatic logic [15:0] f_key(input logic [15:0] k0, input logic [15:0] k1,
                                          input logic [15:0] k3, input logic zbit);
        logic [15:0] tmp;
        tmp = {k3[2:0], k3[15:3]} ^ k1;
        tmp = tmp ^ {tmp[0], tmp[15:1]};
        return ~k0 ^ tmp ^ {15'd0, zbit} ^ 16'h0003;
    endfunction

    // First round of the step.
    logic [15:0] w_x1;
    logic [15:0] w_y1;
    logic [15:0] w_k4;
    assign w_x1 = r_y ^ f_round(r_x) ^ r_k0;
    assign w_y1 = r_x;
    assign w_k4 = f_key(r_k0, r_k1, r_k3, Z0[r_round]);

    logic [15:0] w_x_nxt;
    logic [15:0] w_y_nxt;
    logic [15:0] w_k0_nxt;
    logic [15:0] w_k1_nxt;
    logic [15:0] w_k2_nxt;
    logic [15:0] w_k3_nxt;

`ifdef SIMON_UNROLL2_EN
    // Second cascaded round; r_round is always even here, so +1 never wraps.
    logic [4:0]  w_round_p1;
    logic [15:0] w_x2;
    logic [15:0] w_y2;
    logic [15:0] w_k5;
    assign w_round_p1 = r_round + 5'd1;
    assign w_x2 = w_y1 ^ f_round(w_x1) ^ r_k1;
    assign w_y2 = w_x1;
    assign w_k5 = f_key(r_k1, r_k2, w_k4, Z0[w_round_p1]);

    assign w_x_nxt  = w_x2;
    assign w_y_nxt  = w_y2;
    assign w_k0_nxt = r_k2;
    assign w_k1_nxt = r_k3;
    assign w_k2_nxt = w_k4;
    assign w_k3_nxt = w_k5;
`else
    assign w_x_nxt  = w_x1;
    assign w_y_nxt  = w_y1;
    assign w_k0_nxt = r_k1;
    assign w_k1_nxt = r_k2;
    assign w_k2_nxt = r_k3;
    assign w_k3_nxt = w_k4;
`endif

    // Start is accepted from IDLE and DONE only, so en while busy is ignored.
    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_en) begin
                    w_start      = 1'b1;
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                if (r_round == LAST_ROUND) begin
                    w_last       = 1'b1;
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                if (i_en) begin
                    w_start      = 1'b1;
                    w_next_state = S_RUN;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_x          <= '0;
            r_y          <= '0;
            r_k0         <= '0;
            r_k1         <= '0;
            r_k2         <= '0;
            r_k3         <= '0;
            r_round      <= '0;
            r_ciphertext <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_done  <= w_last;
            if (w_start) begin
                r_x     <= i_plaintext[31:16];
                r_y     <= i_plaintext[15:0];
                r_k0    <= i_key[15:0];
                r_k1    <= i_key[31:16];
                r_k2    <= i_key[47:32];
                r_k3    <= i_key[63:48];
                r_round <= '0;
                r_busy  <= 1'b1;
            end else if (r_state == S_RUN) begin
                r_x  <= w_x_nxt;
                r_y  <= w_y_nxt;
                r_k0 <= w_k0_nxt;
                r_k1 <= w_k1_nxt;
                r_k2 <= w_k2_nxt;
                r_k3 <= w_k3_nxt;
                if (w_last) begin
                    r_ciphertext <= {w_x_nxt, w_y_nxt};
                    r_busy       <= 1'b0;
                end else begin
                    r_round <= r_round + ROUND_INC;
                end
            end
        end
    end

    assign o_ciphertext = r_ciphertext;
    assign o_busy       = r_busy;
    assign o_done       = r_done;

endmodule
